// File: rtl/writeback_regfile.sv
// Writeback stage and architectural register file.
// Two write sources per cycle (memory-stage load, execute-stage ALU) are
// committed one per cycle, in program order, through an in-order pending
// queue. Three combinational read ports see the youngest value in flight.
module writeback_regfile #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16,
    parameter int QDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              do_mem_reg_write,
    input  logic [DATA_W-1:0] mem_value,
    input  logic [3:0]        mem_reg_addr,
    input  logic              do_exe_reg_write,
    input  logic [DATA_W-1:0] exe_result,
    input  logic [3:0]        exe_reg_addr,
    input  logic              do_halt,
    input  logic [3:0]        rd_addr1,
    input  logic [3:0]        rd_addr2,
    input  logic [3:0]        rd_addr3,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] rd_data3,
    output logic              stall,
    output logic              halted,
    output logic              overflow
);

    localparam int AW = 4;
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    // Architectural state
    logic [DATA_W-1:0] regs_q   [NREG];
    logic [DATA_W-1:0] regs_d   [NREG];
    logic [DATA_W-1:0] q_data_q [QDEPTH];
    logic [DATA_W-1:0] q_data_d [QDEPTH];
    logic [AW-1:0]     q_addr_q [QDEPTH];
    logic [AW-1:0]     q_addr_d [QDEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              halt_pending_q, halt_pending_d;
    logic              halted_q, halted_d;
    logic              overflow_q, overflow_d;

    // Commit / push scratch
    logic              mem_v_s, exe_v_s;
    logic              wr_en_s;
    logic [AW-1:0]     wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;
    logic              pop_s;
    logic [1:0]        push_v_s;
    logic [AW-1:0]     push_addr_s [2];
    logic [DATA_W-1:0] push_data_s [2];
    logic [CW-1:0]     cnt_s;

    // Read bypass scratch
    logic [AW-1:0]     rd_addr_s [3];
    logic [DATA_W-1:0] rd_data_s [3];
    logic [PW-1:0]     rd_idx_s;

    // Writes to r0 are dropped, and nothing new is accepted once a halt is pending.
    assign mem_v_s = do_mem_reg_write && (mem_reg_addr != {AW{1'b0}}) && !halt_pending_q;
    assign exe_v_s = do_exe_reg_write && (exe_reg_addr != {AW{1'b0}}) && !halt_pending_q;

    // Pick the oldest candidate for the write port, queue the rest, and track halt/overflow.
    always_comb begin
        regs_d         = regs_q;
        q_data_d       = q_data_q;
        q_addr_d       = q_addr_q;
        head_d         = head_q;
        tail_d         = tail_q;
        overflow_d     = overflow_q;
        pop_s          = 1'b0;
        wr_en_s        = 1'b0;
        wr_addr_s      = {AW{1'b0}};
        wr_data_s      = {DATA_W{1'b0}};
        push_v_s       = 2'b00;
        push_addr_s[0] = mem_reg_addr;
        push_data_s[0] = mem_value;
        push_addr_s[1] = exe_reg_addr;
        push_data_s[1] = exe_result;

        if (count_q != {CW{1'b0}}) begin
            pop_s     = 1'b1;
            wr_en_s   = 1'b1;
            wr_addr_s = q_addr_q[head_q];
            wr_data_s = q_data_q[head_q];
            push_v_s  = {exe_v_s, mem_v_s};
        end else if (mem_v_s) begin
            wr_en_s        = 1'b1;
            wr_addr_s      = mem_reg_addr;
            wr_data_s      = mem_value;
            push_v_s       = {1'b0, exe_v_s};
            push_addr_s[0] = exe_reg_addr;
            push_data_s[0] = exe_result;
        end else if (exe_v_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = exe_reg_addr;
            wr_data_s = exe_result;
        end else begin
            wr_en_s   = 1'b0;
        end

        if (wr_en_s) begin
            regs_d[wr_addr_s] = wr_data_s;
        end else begin
            regs_d[wr_addr_s] = regs_q[wr_addr_s];
        end

        // The pop frees its slot before the pushes look for space.
        if (pop_s) begin
            head_d = head_q + PW'(1);
            cnt_s  = count_q - CW'(1);
        end else begin
            head_d = head_q;
            cnt_s  = count_q;
        end

        for (int p = 0; p < 2; p++) begin
            if (push_v_s[p]) begin
                if (cnt_s < CW'(QDEPTH)) begin
                    q_addr_d[tail_d] = push_addr_s[p];
                    q_data_d[tail_d] = push_data_s[p];
                    tail_d           = tail_d + PW'(1);
                    cnt_s            = cnt_s + CW'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end else begin
                cnt_s = cnt_s;
            end
        end
        count_d = cnt_s;

        halt_pending_d = halt_pending_q | do_halt;
        halted_d       = halted_q | (halt_pending_d && (count_d == {CW{1'b0}}));
    end

    // Per read port: array value, overridden by queue entries head..tail, then mem, then exe.
    always_comb begin
        rd_addr_s[0] = rd_addr1;
        rd_addr_s[1] = rd_addr2;
        rd_addr_s[2] = rd_addr3;
        rd_idx_s     = head_q;
        for (int r = 0; r < 3; r++) begin
            rd_data_s[r] = regs_q[rd_addr_s[r]];
            for (int i = 0; i < QDEPTH; i++) begin
                rd_idx_s = head_q + PW'(i);
                if ((CW'(i) < count_q) && (q_addr_q[rd_idx_s] == rd_addr_s[r])) begin
                    rd_data_s[r] = q_data_q[rd_idx_s];
                end else begin
                    rd_data_s[r] = rd_data_s[r];
                end
            end
            if (mem_v_s && (mem_reg_addr == rd_addr_s[r])) begin
                rd_data_s[r] = mem_value;
            end else begin
                rd_data_s[r] = rd_data_s[r];
            end
            if (exe_v_s && (exe_reg_addr == rd_addr_s[r])) begin
                rd_data_s[r] = exe_result;
            end else begin
                rd_data_s[r] = rd_data_s[r];
            end
            if (rd_addr_s[r] == {AW{1'b0}}) begin
                rd_data_s[r] = {DATA_W{1'b0}};
            end else begin
                rd_data_s[r] = rd_data_s[r];
            end
        end
    end

    // State registers; reset also discards any queued writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            for (int i = 0; i < QDEPTH; i++) begin
                q_data_q[i] <= {DATA_W{1'b0}};
                q_addr_q[i] <= {AW{1'b0}};
            end
            head_q         <= {PW{1'b0}};
            tail_q         <= {PW{1'b0}};
            count_q        <= {CW{1'b0}};
            halt_pending_q <= 1'b0;
            halted_q       <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            regs_q         <= regs_d;
            q_data_q       <= q_data_d;
            q_addr_q       <= q_addr_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            halt_pending_q <= halt_pending_d;
            halted_q       <= halted_d;
            overflow_q     <= overflow_d;
        end
    end

    assign rd_data1 = rd_data_s[0];
    assign rd_data2 = rd_data_s[1];
    assign rd_data3 = rd_data_s[2];
    assign stall    = (count_q >= CW'(QDEPTH - 1));
    assign halted   = halted_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: a vector table for the single-cycle
// behaviour plus hand-written overflow, reset-mid-drain and halt sequences.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        do_mem_reg_write, do_exe_reg_write, do_halt;
    logic [15:0] mem_value, exe_result;
    logic [3:0]  mem_reg_addr, exe_reg_addr;
    logic [3:0]  rd_addr1, rd_addr2, rd_addr3;
    logic [15:0] rd_data1, rd_data2, rd_data3;
    logic        stall, halted, overflow;

    int n_cmp = 0;
    int n_bad = 0;

    writeback_regfile #(.DATA_W(16), .NREG(16), .QDEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .do_mem_reg_write(do_mem_reg_write), .mem_value(mem_value), .mem_reg_addr(mem_reg_addr),
        .do_exe_reg_write(do_exe_reg_write), .exe_result(exe_result), .exe_reg_addr(exe_reg_addr),
        .do_halt(do_halt),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data3(rd_data3),
        .stall(stall), .halted(halted), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mv;  logic [3:0] ma; logic [15:0] md;
        logic        ev;  logic [3:0] ea; logic [15:0] ed;
        logic [3:0]  a1, a2, a3;
        logic [15:0] x1, x2, x3;
        logic        xs;  logic [2:0] xc;
        logic [3:0]  aa;  logic [15:0] av;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input logic mv, input logic [3:0] ma, input logic [15:0] md,
                                input logic ev, input logic [3:0] ea, input logic [15:0] ed,
                                input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                                input logic [15:0] x1, input logic [15:0] x2, input logic [15:0] x3,
                                input logic xs, input logic [2:0] xc,
                                input logic [3:0] aa, input logic [15:0] av);
        vec_t v;
        v.mv = mv; v.ma = ma; v.md = md; v.ev = ev; v.ea = ea; v.ed = ed;
        v.a1 = a1; v.a2 = a2; v.a3 = a3; v.x1 = x1; v.x2 = x2; v.x3 = x3;
        v.xs = xs; v.xc = xc; v.aa = aa; v.av = av;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic [3:0] ma, input logic [15:0] md,
                         input logic ev, input logic [3:0] ea, input logic [15:0] ed);
        do_mem_reg_write = mv; mem_reg_addr = ma; mem_value  = md;
        do_exe_reg_write = ev; exe_reg_addr = ea; exe_result = ed;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        //            mv ma   md        ev ea   ed        a1 a2 a3  x1        x2        x3       xs xc aa  av
        tbl[0]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 2, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000);
        tbl[1]  = mk(1, 3, 16'h7530, 0, 0, 16'h0000, 3, 0, 4, 16'h7530, 16'h0000, 16'h0000, 0, 0, 3, 16'h0000);
        tbl[2]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 3, 3, 5, 16'h7530, 16'h7530, 16'h0000, 0, 0, 3, 16'h7530);
        tbl[3]  = mk(1, 5, 16'h000A, 1, 5, 16'h0014, 5, 3, 0, 16'h0014, 16'h7530, 16'h0000, 0, 0, 5, 16'h0000);
        tbl[4]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 5, 5, 5, 16'h0014, 16'h0014, 16'h0014, 0, 1, 5, 16'h000A);
        tbl[5]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 5, 3, 1, 16'h0014, 16'h7530, 16'h0000, 0, 0, 5, 16'h0014);
        tbl[6]  = mk(1, 1, 16'h0011, 1, 2, 16'h0022, 1, 2, 3, 16'h0011, 16'h0022, 16'h7530, 0, 0, 1, 16'h0000);
        tbl[7]  = mk(1, 3, 16'h0033, 1, 4, 16'h0044, 2, 3, 4, 16'h0022, 16'h0033, 16'h0044, 0, 1, 1, 16'h0011);
        tbl[8]  = mk(1, 5, 16'h0055, 1, 6, 16'h0066, 5, 6, 1, 16'h0055, 16'h0066, 16'h0011, 0, 2, 2, 16'h0022);
        tbl[9]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 4, 5, 6, 16'h0044, 16'h0055, 16'h0066, 1, 3, 3, 16'h0033);
        tbl[10] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 2, 3, 16'h0011, 16'h0022, 16'h0033, 0, 2, 4, 16'h0044);
        tbl[11] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 4, 5, 6, 16'h0044, 16'h0055, 16'h0066, 0, 1, 5, 16'h0055);
        tbl[12] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 5, 6, 3, 16'h0055, 16'h0066, 16'h0033, 0, 0, 6, 16'h0066);
        tbl[13] = mk(0, 0, 16'h0000, 1, 0, 16'hFFFF, 0, 0, 6, 16'h0000, 16'h0000, 16'h0066, 0, 0, 0, 16'h0000);
        tbl[14] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 2, 16'h0000, 16'h0011, 16'h0022, 0, 0, 6, 16'h0066);
        tbl[15] = mk(1, 8, 16'h0081, 1, 9, 16'h0091, 8, 9, 0, 16'h0081, 16'h0091, 16'h0000, 0, 0, 8, 16'h0000);
        tbl[16] = mk(1, 9, 16'h0092, 1, 9, 16'h0093, 9, 8, 9, 16'h0093, 16'h0081, 16'h0093, 0, 1, 8, 16'h0081);
        tbl[17] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 9, 9, 8, 16'h0093, 16'h0093, 16'h0081, 0, 2, 9, 16'h0091);
        tbl[18] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 9, 1, 2, 16'h0093, 16'h0011, 16'h0022, 0, 1, 9, 16'h0092);
        tbl[19] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 9, 8, 7, 16'h0093, 16'h0081, 16'h0000, 0, 0, 9, 16'h0093);

        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
        do_halt = 1'b0;
        rd_addr1 = 4'd0; rd_addr2 = 4'd0; rd_addr3 = 4'd0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state: every register reads zero, flags clear.
        for (int a = 0; a < 16; a++) begin
            rd_addr1 = 4'(a);
            #1;
            chk($sformatf("reset_r%0d", a), 32'(rd_data1), 32'h0);
        end
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_halted", 32'(halted), 32'h0);
        chk("reset_overflow", 32'(overflow), 32'h0);
        step();

        // Table: inputs applied after the edge, outputs checked at the falling edge.
        for (int k = 0; k < 20; k++) begin
            drive(tbl[k].mv, tbl[k].ma, tbl[k].md, tbl[k].ev, tbl[k].ea, tbl[k].ed);
            rd_addr1 = tbl[k].a1; rd_addr2 = tbl[k].a2; rd_addr3 = tbl[k].a3;
            @(negedge clk);
            chk($sformatf("v%0d_rd1", k), 32'(rd_data1), 32'(tbl[k].x1));
            chk($sformatf("v%0d_rd2", k), 32'(rd_data2), 32'(tbl[k].x2));
            chk($sformatf("v%0d_rd3", k), 32'(rd_data3), 32'(tbl[k].x3));
            chk($sformatf("v%0d_stall", k), 32'(stall), 32'(tbl[k].xs));
            chk($sformatf("v%0d_count", k), 32'(dut.count_q), 32'(tbl[k].xc));
            chk($sformatf("v%0d_array", k), 32'(dut.regs_q[tbl[k].aa]), 32'(tbl[k].av));
            chk($sformatf("v%0d_overflow", k), 32'(overflow), 32'h0);
            chk($sformatf("v%0d_halted", k), 32'(halted), 32'h0);
            step();
        end
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);

        // Overflow: dual writes every cycle ignoring stall; the fifth exe write is lost.
        pulse_reset();
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 4'(2 * c + 1), 16'(2 * c + 1), 1'b1, 4'(2 * c + 2), 16'(2 * c + 2));
            @(negedge clk);
            if (c == 3) begin
                chk("ovf_c3_stall", 32'(stall), 32'h1);
                chk("ovf_c3_overflow", 32'(overflow), 32'h0);
            end else if (c == 4) begin
                chk("ovf_c4_stall", 32'(stall), 32'h1);
                chk("ovf_c4_overflow", 32'(overflow), 32'h0);
            end
            step();
        end
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
        @(negedge clk);
        chk("ovf_set", 32'(overflow), 32'h1);
        chk("ovf_count_full", 32'(dut.count_q), 32'h4);
        repeat (5) step();
        rd_addr1 = 4'd9; rd_addr2 = 4'd10; rd_addr3 = 4'd8;
        @(negedge clk);
        chk("ovf_drain_count", 32'(dut.count_q), 32'h0);
        chk("ovf_r9", 32'(rd_data1), 32'h9);
        chk("ovf_r10_dropped", 32'(rd_data2), 32'h0);
        chk("ovf_r8", 32'(rd_data3), 32'h8);
        chk("ovf_sticky", 32'(overflow), 32'h1);
        chk("ovf_stall_clear", 32'(stall), 32'h0);
        step();

        // Refill to count=2 then reset mid-drain: queue contents must vanish.
        drive(1'b1, 4'd11, 16'h00B1, 1'b1, 4'd12, 16'h00C1);
        step();
        drive(1'b1, 4'd13, 16'h00D1, 1'b1, 4'd14, 16'h00E1);
        step();
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
        @(negedge clk);
        chk("mid_count_before", 32'(dut.count_q), 32'h2);
        pulse_reset();
        rd_addr1 = 4'd13; rd_addr2 = 4'd14; rd_addr3 = 4'd11;
        @(negedge clk);
        chk("mid_count_after", 32'(dut.count_q), 32'h0);
        chk("mid_r13", 32'(rd_data1), 32'h0);
        chk("mid_r14", 32'(rd_data2), 32'h0);
        chk("mid_r11", 32'(rd_data3), 32'h0);
        chk("mid_overflow", 32'(overflow), 32'h0);
        step();

        // Halt with a pending queue.
        pulse_reset();
        drive(1'b1, 4'd1, 16'h0001, 1'b1, 4'd2, 16'h0002);
        step();
        drive(1'b1, 4'd3, 16'h0003, 1'b1, 4'd4, 16'h0004);
        step();
        drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 16'h0009);
        do_halt = 1'b1;
        @(negedge clk);
        chk("halt_c2_count", 32'(dut.count_q), 32'h2);
        step();
        do_halt = 1'b0;
        drive(1'b1, 4'd8, 16'h0001, 1'b0, 4'd0, 16'h0000);
        rd_addr1 = 4'd8; rd_addr2 = 4'd7; rd_addr3 = 4'd4;
        @(negedge clk);
        chk("halt_c3_r8_ignored", 32'(rd_data1), 32'h0);
        chk("halt_c3_r7", 32'(rd_data2), 32'h9);
        chk("halt_c3_r4", 32'(rd_data3), 32'h4);
        chk("halt_c3_count", 32'(dut.count_q), 32'h2);
        chk("halt_c3_halted", 32'(halted), 32'h0);
        step();
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
        @(negedge clk);
        chk("halt_c4_count", 32'(dut.count_q), 32'h1);
        chk("halt_c4_halted", 32'(halted), 32'h0);
        step();
        rd_addr1 = 4'd7; rd_addr2 = 4'd8; rd_addr3 = 4'd3;
        @(negedge clk);
        chk("halt_c5_halted", 32'(halted), 32'h1);
        chk("halt_c5_count", 32'(dut.count_q), 32'h0);
        chk("halt_c5_r7", 32'(dut.regs_q[7]), 32'h9);
        chk("halt_c5_rd_r7", 32'(rd_data1), 32'h9);
        chk("halt_c5_rd_r8", 32'(rd_data2), 32'h0);
        chk("halt_c5_rd_r3", 32'(rd_data3), 32'h3);
        do_halt = 1'b1;
        drive(1'b1, 4'd8, 16'h0005, 1'b0, 4'd0, 16'h0000);
        step();
        do_halt = 1'b0;
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
        @(negedge clk);
        chk("halt_c6_halted", 32'(halted), 32'h1);
        chk("halt_c6_rd_r8", 32'(rd_data2), 32'h0);
        chk("halt_c6_count", 32'(dut.count_q), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
